parking_gate_controller: RTL

PARKING_GATE_CONTROLLER -- requirements
Module: parking_gate_controller

---
 rtl/parking_gate_controller.sv | 87 ++++++++
 1 files changed

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: 8-slot car park gate FSM with occupancy bitmap and timed gates.
// Optional PARKING_REJECT_COUNT_EN adds a saturating rejected-entry counter.
module parking_gate_controller #(
   parameter int GATE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       entry,
   input  logic       exit_req,
   input  logic [2:0] exit_slot,
   output logic [7:0] parking_capacity,
   output logic       full,
   output logic [3:0] free_count,
   output logic       entry_gate,
   output logic       exit_gate,
   output logic [2:0] assigned_slot,
   output logic       entry_grant,
   output logic       entry_reject,
   output logic       exit_grant,
   output logic       exit_error,
   output logic [7:0] reject_count
);
   localparam logic [1:0] IDLE = 2'd0, ENTRY_OPEN = 2'd1, EXIT_OPEN = 2'd2;
   localparam logic [7:0] GC = 8'(GATE_CYCLES);
   logic [1:0] state;
   logic [7:0] cnt;
   logic [2:0] low;
   logic       rej_hold, idle, do_exit, do_err, do_entry, do_rej;
   always_comb begin
      low = 3'd0;
      for (int i = 7; i >= 0; i--) if (!parking_capacity[i]) low = 3'(i);
   end
   always_comb begin
      free_count = 4'd0;
      for (int i = 0; i < 8; i++) free_count = free_count + {3'd0, ~parking_capacity[i]};
   end
   assign full       = &parking_capacity;
   assign entry_gate = state == ENTRY_OPEN;
   assign exit_gate  = state == EXIT_OPEN;
   assign idle       = state == IDLE;
   assign do_exit    = idle && exit_req && parking_capacity[exit_slot];
   assign do_err     = idle && exit_req && !parking_capacity[exit_slot];
   // a held entry that was already rejected stays ignored until it drops
   assign do_entry   = idle && !exit_req && entry && !rej_hold && !full;
   assign do_rej     = idle && !exit_req && entry && !rej_hold && full;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         cnt              <= 8'd0;
         parking_capacity <= 8'd0;
         assigned_slot    <= 3'd0;
         rej_hold         <= 1'b0;
         entry_grant      <= 1'b0;
         entry_reject     <= 1'b0;
         exit_grant       <= 1'b0;
         exit_error       <= 1'b0;
      end else begin
         entry_grant  <= do_entry;
         entry_reject <= do_rej;
         exit_grant   <= do_exit;
         exit_error   <= do_err;
         if (!entry) rej_hold <= 1'b0;
         if (do_rej) rej_hold <= 1'b1;
         if (do_exit) begin
            state                       <= EXIT_OPEN;
            cnt                         <= GC;
            parking_capacity[exit_slot] <= 1'b0;
         end else if (do_entry) begin
            state                 <= ENTRY_OPEN;
            cnt                   <= GC;
            parking_capacity[low] <= 1'b1;
            assigned_slot         <= low;
         end else if (!idle) begin
            state <= cnt <= 8'd1 ? IDLE : state;
            cnt   <= cnt - 8'd1;
         end
      end
   end
`ifdef PARKING_REJECT_COUNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) reject_count <= 8'd0;
      else if (do_rej && reject_count != 8'hFF) reject_count <= reject_count + 8'd1;
   end
`else
   assign reject_count = 8'd0;
`endif
endmodule
